// File: rtl/polygon_loader.sv
// polygon_loader: fetches one polygon's vertex list from memory per frame, one read at a time.
// Define POLY_DOUBLE_BUF_EN to stage captures in shadow arrays and swap them in atomically at commit.
module polygon_loader #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int ADDR_BITS        = 8,
  localparam int CNT_BITS        = $clog2(MAX_NUM_VERTICES + 1),
  localparam int IDX_BITS        = $clog2(MAX_NUM_VERTICES)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         frame_start_in,
  input  logic [ADDR_BITS-1:0]         base_addr_in,
  input  logic [CNT_BITS-1:0]          count_in,
  output logic                         mem_req_out,
  output logic [ADDR_BITS-1:0]         mem_addr_out,
  input  logic                         mem_valid_in,
  input  logic signed [WORLD_BITS-1:0] mem_x_in,
  input  logic signed [WORLD_BITS-1:0] mem_y_in,
  output logic signed [WORLD_BITS-1:0] xs_out [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0] ys_out [MAX_NUM_VERTICES],
  output logic [CNT_BITS-1:0]          num_points_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         error_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] base_q;
  logic [CNT_BITS-1:0]  count_q;
  logic [IDX_BITS-1:0]  index;
  logic [IDX_BITS-1:0]  index_next;
  logic                 count_ok;
  logic                 last;

`ifdef POLY_DOUBLE_BUF_EN
  logic signed [WORLD_BITS-1:0] shadow_x [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] shadow_y [MAX_NUM_VERTICES];
`endif

  assign count_ok   = (count_in >= CNT_BITS'(3)) && (count_in <= CNT_BITS'(MAX_NUM_VERTICES));
  assign last       = (CNT_BITS'(index) == count_q - CNT_BITS'(1));
  assign index_next = index + 1'b1;

  // Final capture and commit land on the same edge so done_out, num_points_out
  // and the vertex arrays all become visible together in the COMMIT cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      index          <= '0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= '0;
      num_points_out <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      error_out      <= 1'b0;
      for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
        xs_out[k] <= '0;
        ys_out[k] <= '0;
`ifdef POLY_DOUBLE_BUF_EN
        shadow_x[k] <= '0;
        shadow_y[k] <= '0;
`endif
      end
    end else begin
      mem_req_out <= 1'b0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start_in) begin
            if (count_ok) begin
              base_q       <= base_addr_in;
              count_q      <= count_in;
              index        <= '0;
              mem_req_out  <= 1'b1;
              mem_addr_out <= base_addr_in;
              busy_out     <= 1'b1;
              state        <= REQ;
            end else begin
              error_out <= 1'b1;
            end
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (mem_valid_in) begin
`ifdef POLY_DOUBLE_BUF_EN
            shadow_x[index] <= mem_x_in;
            shadow_y[index] <= mem_y_in;
            if (last) begin
              for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
                xs_out[k] <= (IDX_BITS'(k) == index) ? mem_x_in : shadow_x[k];
                ys_out[k] <= (IDX_BITS'(k) == index) ? mem_y_in : shadow_y[k];
              end
            end
`else
            xs_out[index] <= mem_x_in;
            ys_out[index] <= mem_y_in;
`endif
            if (last) begin
              num_points_out <= count_q;
              done_out       <= 1'b1;
              state          <= COMMIT;
            end else begin
              index        <= index_next;
              mem_req_out  <= 1'b1;
              mem_addr_out <= base_q + ADDR_BITS'(index_next);
              state        <= REQ;
            end
          end
        end
        COMMIT: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (frame_start_in && (state != IDLE)) begin
        error_out <= 1'b1;
      end
    end
  end

endmodule
